// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//   Multicycle program-counter controller. It steps through FETCH -> EXEC ->
//   UPDATE for each instruction, owns the PC register, resolves branch/jump
//   control at the end of execute into the next-PC mux control word, and
//   counts retired instructions.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   imem_req          fetch request (FETCH state, suppressed while in reset)
//   imem_addr         fetch address, mirrors pc
//   imem_ack          instruction memory returned data (honoured in FETCH)
//   instr_valid       one-cycle pulse on the first EXEC cycle
//   exec_done         datapath finished executing (honoured in EXEC)
//   branch/zero/jump  control flags, sampled on the exec_done cycle
//   target_branch     branch target address (read during UPDATE)
//   target_jump       jump target address (read during UPDATE)
//   pc_sel            mux control word {source class[1:0], branch cond}
//   pc_write          PC load strobe (UPDATE state)
//   pc, pc_plus4      current PC and PC+4 (mod 2^32)
//   retired           retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] target_branch,
    input  logic [31:0] target_jump,
    output logic [2:0]  pc_sel,
    output logic        pc_write,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        first_exec;    // set only for the cycle right after the ack
    logic [2:0]  sel_q;
    logic [2:0]  sel_next;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] retired_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            first_exec <= 1'b0;
            sel_q      <= 3'b000;
            pc_q       <= RESET_VECTOR;
            retired_q  <= 32'd0;
        end else begin
            state      <= state_next;
            // Marks the first EXEC cycle so instr_valid stays a single pulse
            // even when exec_done is late.
            first_exec <= (state == S_FETCH) && imem_ack;
            if ((state == S_EXEC) && exec_done) begin
                sel_q <= sel_next;
            end
            if (state == S_UPDATE) begin
                pc_q      <= pc_next;
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (imem_ack)  state_next = S_EXEC;
            S_EXEC:   if (exec_done) state_next = S_UPDATE;
            S_UPDATE: state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Control-word resolution: jump outranks branch
    // ------------------------------------------------------------------
    always_comb begin
        sel_next = 3'b000;
        if (jump) begin
            sel_next = 3'b100;
        end else if (branch) begin
            sel_next = {2'b01, zero};
        end
    end

    // ------------------------------------------------------------------
    // Next-PC mux. Targets are word-aligned by clearing bits [1:0].
    // Class 11 is never produced by this block but is decoded so the mux
    // is fully specified.
    // ------------------------------------------------------------------
    always_comb begin
        pc_next = pc_plus4;
        case (sel_q[2:1])
            2'b00: pc_next = pc_plus4;
            2'b10: pc_next = {target_jump[31:2], 2'b00};
            2'b01: pc_next = sel_q[0] ? {target_branch[31:2], 2'b00} : pc_plus4;
            2'b11: pc_next = {target_branch[31:2], 2'b00};
            default: pc_next = pc_plus4;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes decode the registered state only; imem_req is also
    // held low while reset is asserted so no fetch is issued during reset.
    // ------------------------------------------------------------------
    assign imem_req    = (state == S_FETCH) && !reset;
    assign instr_valid = (state == S_EXEC) && first_exec;
    assign pc_write    = (state == S_UPDATE);
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign pc_sel      = sel_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed and randomized instruction sequences. A transaction-level model
//   tracks the architectural PC, retired count and control word, and each
//   instruction is checked cycle by cycle against the expected handshake.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        exec_done;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] target_branch;
    logic [31:0] target_jump;
    logic [2:0]  pc_sel;
    logic        pc_write;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;

    pc_sequencer #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .instr_valid(instr_valid), .exec_done(exec_done),
        .branch(branch), .zero(zero), .jump(jump),
        .target_branch(target_branch), .target_jump(target_jump),
        .pc_sel(pc_sel), .pc_write(pc_write), .pc(pc),
        .pc_plus4(pc_plus4), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Architectural model state
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [2:0]  m_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ctl();
        branch = 1'($urandom);
        zero   = 1'($urandom);
        jump   = 1'($urandom);
    endtask

    // One instruction: ad cycles without ack, ed cycles without exec_done.
    task automatic run_instr(input int ad, input int ed, input bit br, input bit z,
                             input bit j, input logic [31:0] tb_a, input logic [31:0] tj_a);
        logic [31:0] exp_pc;
        logic [2:0]  exp_sel;
        int iv_cnt;
        int pw_cnt;
        iv_cnt = 0;
        pw_cnt = 0;
        exp_sel = j ? 3'b100 : (br ? {2'b01, z} : 3'b000);
        if (j)           exp_pc = tj_a & 32'hFFFF_FFFC;
        else if (br & z) exp_pc = tb_a & 32'hFFFF_FFFC;
        else             exp_pc = m_pc + 32'd4;
        target_branch = tb_a;
        target_jump   = tj_a;

        // FETCH: stray exec_done must have no effect
        for (int i = 0; i <= ad; i++) begin
            check("fetch_req",   {31'd0, imem_req}, 32'd1);
            check("fetch_addr",  imem_addr, m_pc);
            check("fetch_pc",    pc, m_pc);
            check("fetch_sel",   {29'd0, pc_sel}, {29'd0, m_sel});
            check("fetch_ret",   retired, m_ret);
            iv_cnt += int'(instr_valid);
            pw_cnt += int'(pc_write);
            imem_ack  = (i == ad);
            exec_done = 1'($urandom);
            scramble_ctl();
            tick();
        end

        // EXEC: stray ack must have no effect
        for (int i = 0; i <= ed; i++) begin
            check("exec_iv",  {31'd0, instr_valid}, (i == 0) ? 32'd1 : 32'd0);
            check("exec_req", {31'd0, imem_req}, 32'd0);
            check("exec_pc",  pc, m_pc);
            check("exec_sel", {29'd0, pc_sel}, {29'd0, m_sel});
            iv_cnt += int'(instr_valid);
            pw_cnt += int'(pc_write);
            imem_ack  = 1'($urandom);
            exec_done = (i == ed);
            if (i == ed) begin
                branch = br;
                zero   = z;
                jump   = j;
            end else begin
                scramble_ctl();
            end
            tick();
        end

        // UPDATE
        check("upd_sel", {29'd0, pc_sel}, {29'd0, exp_sel});
        check("upd_pc",  pc, m_pc);
        check("upd_req", {31'd0, imem_req}, 32'd0);
        iv_cnt += int'(instr_valid);
        pw_cnt += int'(pc_write);
        imem_ack  = 1'($urandom);
        exec_done = 1'($urandom);
        scramble_ctl();
        tick();

        // Back in FETCH with the new PC
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        check("iv_pulses", iv_cnt, 1);
        check("pw_pulses", pw_cnt, 1);
        check("new_pc",    pc, exp_pc);
        check("new_addr",  imem_addr, exp_pc);
        check("new_plus4", pc_plus4, exp_pc + 32'd4);
        check("new_ret",   retired, m_ret + 32'd1);
        check("new_req",   {31'd0, imem_req}, 32'd1);
        check("new_sel",   {29'd0, pc_sel}, {29'd0, exp_sel});
        m_pc  = exp_pc;
        m_ret = m_ret + 32'd1;
        m_sel = exp_sel;
    endtask

    initial begin
        reset = 1'b1;
        imem_ack = 1'b0;
        exec_done = 1'b0;
        branch = 1'b0;
        zero = 1'b0;
        jump = 1'b0;
        target_branch = 32'd0;
        target_jump = 32'd0;
        tick();
        tick();

        // Reset state
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_pc",    pc, RV);
        check("rst_ret",   retired, 32'd0);
        check("rst_sel",   {29'd0, pc_sel}, 32'd0);
        check("rst_pw",    {31'd0, pc_write}, 32'd0);
        check("rst_iv",    {31'd0, instr_valid}, 32'd0);
        reset = 1'b0;
        m_pc  = RV;
        m_ret = 0;
        m_sel = 3'b000;
        #1;

        // Sequential, best case
        run_instr(0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_2002);
        check("seq_pc", pc, 32'h0040_0004);
        // Taken branch
        run_instr(0, 0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_2002);
        check("taken_pc", pc, 32'h0000_0100);
        // Not-taken branch
        run_instr(0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_2002);
        check("ntaken_pc", pc, 32'h0000_0104);
        // Jump and branch both high, misaligned target
        run_instr(0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_2002);
        check("jump_pc", pc, 32'h0000_2000);
        // Stalls: 3 cycles no ack, 2 cycles no exec_done
        run_instr(3, 2, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0300);
        // Wrap: jump to top of memory then fall through
        run_instr(1, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
        check("top_pc", pc, 32'hFFFF_FFFC);
        run_instr(0, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
        check("wrap_pc", pc, 32'h0000_0000);

        // Reset during EXEC with exec_done
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("pre_rst_iv", {31'd0, instr_valid}, 32'd1);
        exec_done = 1'b1;
        jump = 1'b1;
        reset = 1'b1;
        tick();
        exec_done = 1'b0;
        jump = 1'b0;
        check("mid_rst_pc",  pc, RV);
        check("mid_rst_ret", retired, 32'd0);
        check("mid_rst_pw",  {31'd0, pc_write}, 32'd0);
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_sel", {29'd0, pc_sel}, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_pw",  {31'd0, pc_write}, 32'd0);
        check("post_rst_pc",  pc, RV);
        m_pc  = RV;
        m_ret = 0;
        m_sel = 3'b000;

        // Randomized instructions
        for (int k = 0; k < 30; k++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                      $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
